// File: rtl/frame_buf_writer.sv
// -----------------------------------------------------------------------------
// frame_buf_writer
//   Write side of a single-port image frame buffer. Captures one raster-order
//   IMG_W x IMG_H frame from a valid/ready pixel stream into BRAM port A, then
//   releases the memory. wr_active tells the display to blank this pane while
//   the frame is being written.
//
// Ports
//   pclk       in   clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   one-cycle request to capture one frame (honoured in IDLE only)
//   s_valid    in   input pixel valid
//   s_sof      in   marks s_data as pixel (0,0)
//   s_data     in   input pixel
//   s_ready    out  writer accepts a beat this cycle (function of state only)
//   wea        out  BRAM write enable (registered)
//   addra      out  BRAM write address row*IMG_W+col (registered)
//   dina       out  BRAM write data (registered)
//   wr_active  out  high from the cycle after an accepted start through the done cycle
//   done       out  one-cycle pulse, full frame written
//   frame_err  out  one-cycle pulse, s_sof seen mid-frame (frame restarted at 0)
// -----------------------------------------------------------------------------
module frame_buf_writer #(
   parameter int IMG_W  = 200,
   parameter int IMG_H  = 200,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic              s_sof,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [DATA_W-1:0] dina,
   output logic              wr_active,
   output logic              done,
   output logic              frame_err
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_WRITE    = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // Address of the last pixel, compared at the full counter width.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_next_addr;   // address the next non-SOF beat writes
   logic                w_beat;
   logic                w_write;
   logic                w_err;
   logic [ADDR_W-1:0]   w_wr_addr;

   logic                r_wea;
   logic [ADDR_W-1:0]   r_addra;
   logic [DATA_W-1:0]   r_dina;
   logic                r_wr_active;
   logic                r_done;
   logic                r_frame_err;

   // Ready depends on state alone, so no input reaches an output combinationally.
   assign s_ready   = (r_state == ST_WAIT_SOF) || (r_state == ST_WRITE);
   assign wea       = r_wea;
   assign addra     = r_addra;
   assign dina      = r_dina;
   assign wr_active = r_wr_active;
   assign done      = r_done;
   assign frame_err = r_frame_err;

   // Next-state and write-decision logic.
   always_comb begin
      w_next_state = r_state;
      w_write      = 1'b0;
      w_err        = 1'b0;
      w_wr_addr    = r_next_addr;
      w_beat       = s_valid & s_ready;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_WAIT_SOF;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WAIT_SOF: begin
            // Junk before the first SOF is consumed without writing.
            if (w_beat && s_sof) begin
               w_write   = 1'b1;
               w_wr_addr = '0;
               if (LAST_ADDR == '0) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_WRITE;
               end
            end else begin
               w_next_state = ST_WAIT_SOF;
            end
         end
         ST_WRITE: begin
            if (w_beat) begin
               w_write = 1'b1;
               // A mid-frame SOF restarts the frame at pixel 0.
               if (s_sof) begin
                  w_err     = 1'b1;
                  w_wr_addr = '0;
               end else begin
                  w_wr_addr = r_next_addr;
               end
               if (w_wr_addr == LAST_ADDR) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_WRITE;
               end
            end else begin
               w_next_state = ST_WRITE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register and registered BRAM/status outputs.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_next_addr <= '0;
         r_wea       <= 1'b0;
         r_addra     <= '0;
         r_dina      <= '0;
         r_wr_active <= 1'b0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_wea       <= w_write;
         if (w_write) begin
            r_addra     <= w_wr_addr;
            r_dina      <= s_data;
            r_next_addr <= w_wr_addr + ADDR_W'(1);
         end else begin
            r_addra     <= r_addra;
            r_dina      <= r_dina;
            r_next_addr <= r_next_addr;
         end
         r_wr_active <= (w_next_state != ST_IDLE);
         r_done      <= (w_next_state == ST_DONE);
         r_frame_err <= w_err;
      end
   end

endmodule

// File: tb/tb_frame_buf_writer.sv
module tb_frame_buf_writer;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 3;
   localparam int TOTAL  = IMG_W * IMG_H;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int MAXB   = 64;

   logic              pclk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              s_valid;
   logic              s_sof;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] dina;
   logic              wr_active;
   logic              done;
   logic              frame_err;

   int n_checks = 0;
   int n_pass   = 0;

   // stimulus beats
   bit          b_sof  [MAXB];
   logic [7:0]  b_data [MAXB];
   int          nb;

   // reference model results
   bit          m_wr   [MAXB];
   bit          m_err  [MAXB];
   bit          m_last [MAXB];
   int          m_addr [MAXB];
   int          m_nacc;
   logic [7:0]  m_mem  [TOTAL];
   logic [7:0]  obs_mem[TOTAL];

   frame_buf_writer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
      .s_sof(s_sof), .s_data(s_data), .s_ready(s_ready), .wea(wea),
      .addra(addra), .dina(dina), .wr_active(wr_active), .done(done),
      .frame_err(frame_err)
   );

   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // Frame rules applied beat by beat: junk before SOF is dropped, SOF writes
   // pixel 0, every later beat writes the following pixel, the frame ends on
   // the last pixel and nothing after it is taken.
   task automatic model_frame();
      int  addr;
      bit  started;
      addr    = 0;
      started = 1'b0;
      m_nacc  = nb;
      for (int i = 0; i < MAXB; i++) begin
         m_wr[i] = 1'b0; m_err[i] = 1'b0; m_last[i] = 1'b0; m_addr[i] = 0;
      end
      for (int i = 0; i < nb; i++) begin
         if (b_sof[i]) begin
            m_err[i] = started;
            addr     = 0;
            started  = 1'b1;
            m_wr[i]  = 1'b1;
         end else if (started) begin
            addr    = addr + 1;
            m_wr[i] = 1'b1;
         end
         m_addr[i] = addr;
         if (m_wr[i]) m_mem[addr] = b_data[i];
         if (m_wr[i] && addr == TOTAL - 1) begin
            m_last[i] = 1'b1;
            m_nacc    = i + 1;
            break;
         end
      end
   endtask

   task automatic run_frame(input string nm, input int stall_pct, input bit noise_start);
      int  i;
      int  waitc;
      bit  acc;
      bit  exp_wea;
      model_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (wr_active !== 1'b1) $display("FAIL %s_start_active: got %b want 1", nm, wr_active); else n_pass++;
      i = 0;
      waitc = 0;
      while (i < m_nacc) begin
         s_valid = ($urandom_range(99) >= stall_pct);
         s_sof   = b_sof[i];
         s_data  = b_data[i];
         start   = noise_start ? 1'($urandom_range(1)) : 1'b0;
         n_checks++; if (s_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", nm, s_ready); else n_pass++;
         acc = s_valid && s_ready;
         tick();
         exp_wea = acc && m_wr[i];
         n_checks++; if (wea !== exp_wea) $display("FAIL %s_wea beat %0d: got %b want %b", nm, i, wea, exp_wea); else n_pass++;
         if (exp_wea) begin
            n_checks++; if (addra !== ADDR_W'(m_addr[i])) $display("FAIL %s_addra beat %0d: got %0d want %0d", nm, i, addra, m_addr[i]); else n_pass++;
            n_checks++; if (dina !== b_data[i]) $display("FAIL %s_dina beat %0d: got %h want %h", nm, i, dina, b_data[i]); else n_pass++;
         end
         if (wea === 1'b1 && addra < TOTAL) obs_mem[addra] = dina;
         n_checks++; if (frame_err !== (acc && m_err[i])) $display("FAIL %s_frame_err beat %0d: got %b want %b", nm, i, frame_err, acc && m_err[i]); else n_pass++;
         n_checks++; if (done !== (acc && m_last[i])) $display("FAIL %s_done beat %0d: got %b want %b", nm, i, done, acc && m_last[i]); else n_pass++;
         n_checks++; if (wr_active !== 1'b1) $display("FAIL %s_wr_active beat %0d: got %b want 1", nm, i, wr_active); else n_pass++;
         if (acc) i++;
         waitc++;
         if (waitc > 2000) begin
            n_checks++;
            $display("FAIL %s_timeout: accepted %0d want %0d beats", nm, i, m_nacc);
            break;
         end
      end
      s_valid = 1'b0;
      start   = 1'b0;
      // now in the done cycle
      n_checks++; if (s_ready !== 1'b0) $display("FAIL %s_done_ready: got %b want 0", nm, s_ready); else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL %s_done_len: got %b want 0", nm, done); else n_pass++;
      n_checks++; if (wr_active !== 1'b0) $display("FAIL %s_active_fall: got %b want 0", nm, wr_active); else n_pass++;
      n_checks++; if (wea !== 1'b0) $display("FAIL %s_post_wea: got %b want 0", nm, wea); else n_pass++;
      for (int a = 0; a < TOTAL; a++) begin
         n_checks++; if (obs_mem[a] !== m_mem[a]) $display("FAIL %s_mem[%0d]: got %h want %h", nm, a, obs_mem[a], m_mem[a]); else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      n_checks++; if ({wea, s_ready, wr_active, done, frame_err} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {wea, s_ready, wr_active, done, frame_err}); else n_pass++;
      n_checks++; if (addra !== '0) $display("FAIL reset_addra: got %0d want 0", addra); else n_pass++;
      n_checks++; if (dina !== '0) $display("FAIL reset_dina: got %h want 00", dina); else n_pass++;
   endtask

   task automatic test_full_frame();
      nb = TOTAL;
      for (int i = 0; i < nb; i++) begin
         b_sof[i]  = (i == 0);
         b_data[i] = 8'h10 + 8'(i);
      end
      run_frame("full", 0, 1'b0);
   endtask

   task automatic test_pre_sof_junk();
      nb = 5 + TOTAL;
      for (int i = 0; i < nb; i++) begin
         b_sof[i]  = (i == 5);
         b_data[i] = (i == 5) ? 8'hAA : 8'($urandom_range(255));
      end
      run_frame("junk", 0, 1'b0);
      n_checks++; if (obs_mem[0] !== 8'hAA) $display("FAIL junk_addr0: got %h want aa", obs_mem[0]); else n_pass++;
   endtask

   task automatic test_stalls();
      nb = TOTAL;
      for (int i = 0; i < nb; i++) begin
         b_sof[i]  = (i == 0);
         b_data[i] = 8'($urandom_range(255));
      end
      run_frame("stall", 50, 1'b0);
   endtask

   task automatic test_mid_sof();
      nb = 7 + TOTAL;
      for (int i = 0; i < nb; i++) begin
         b_sof[i]  = (i == 0) || (i == 7);
         b_data[i] = (i == 7) ? 8'h55 : 8'($urandom_range(255));
      end
      run_frame("midsof", 20, 1'b0);
      n_checks++; if (obs_mem[0] !== 8'h55) $display("FAIL midsof_addr0: got %h want 55", obs_mem[0]); else n_pass++;
   endtask

   task automatic test_ignored_start_overrun();
      nb = TOTAL;
      for (int i = 0; i < nb; i++) begin
         b_sof[i]  = (i == 0);
         b_data[i] = 8'($urandom_range(255));
      end
      run_frame("noise", 30, 1'b1);
      // beats offered after the frame is complete must not be taken
      for (int k = 0; k < 4; k++) begin
         s_valid = 1'b1;
         s_sof   = 1'($urandom_range(1));
         s_data  = 8'($urandom_range(255));
         n_checks++; if (s_ready !== 1'b0) $display("FAIL overrun_ready: got %b want 0", s_ready); else n_pass++;
         tick();
         n_checks++; if (wea !== 1'b0) $display("FAIL overrun_wea: got %b want 0", wea); else n_pass++;
         n_checks++; if (wr_active !== 1'b0) $display("FAIL overrun_active: got %b want 0", wr_active); else n_pass++;
      end
      s_valid = 1'b0;
      for (int i = 0; i < nb; i++) b_data[i] = 8'($urandom_range(255));
      run_frame("second", 10, 1'b0);
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_sof   = (i == 0);
         s_data  = 8'($urandom_range(255));
         tick();
      end
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      n_checks++; if ({wea, s_ready, wr_active, done, frame_err} !== 5'b0) $display("FAIL rstmid_flags: got %b want 00000", {wea, s_ready, wr_active, done, frame_err}); else n_pass++;
      n_checks++; if (addra !== '0) $display("FAIL rstmid_addra: got %0d want 0", addra); else n_pass++;
      n_checks++; if (dina !== '0) $display("FAIL rstmid_dina: got %h want 00", dina); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if ({wea, s_ready, wr_active} !== 3'b0) $display("FAIL rstmid_idle: got %b want 000", {wea, s_ready, wr_active}); else n_pass++;
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic test_random_frames();
      int junk;
      for (int f = 0; f < 4; f++) begin
         junk = $urandom_range(3);
         nb   = 40;
         for (int i = 0; i < nb; i++) begin
            if (i < junk)             b_sof[i] = 1'b0;
            else if (i == junk)       b_sof[i] = 1'b1;
            else if (i < junk + 15)   b_sof[i] = ($urandom_range(9) == 0);
            else                      b_sof[i] = 1'b0;
            b_data[i] = 8'($urandom_range(255));
         end
         run_frame("random", 25, 1'b1);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = '0;
      for (int a = 0; a < TOTAL; a++) begin
         m_mem[a]   = 8'h00;
         obs_mem[a] = 8'h00;
      end
      test_reset();
      test_full_frame();
      test_pre_sof_junk();
      test_stalls();
      test_mid_sof();
      test_ignored_start_overrun();
      test_reset_mid();
      test_full_frame();
      test_random_frames();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
